// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Purpose  : Shared types and constants for the digit-recognition datapath.
//            - State encoding of the weight-ROM MAC sequencer.
//            - Default accumulator and result widths.
//            - Product width of a signed 16-bit weight times an unsigned
//              8-bit activation.
// Revision : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;

    // 16-bit signed weight x 9-bit signed (zero-extended 8-bit) activation
    localparam int PROD_W = 25;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN1 = 3'd3,
        ST_DRAIN2 = 3'd4,
        ST_DONE   = 3'd5
    } mac_state_e;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/sat_shift.sv
`default_nettype none
// ============================================================================
// Module   : sat_shift
// Purpose  : Combinational arithmetic right shift followed by saturation of
//            a signed value to a narrower signed width.
// Ports    : acc_i    in  IN_W   signed input value
//            result_o out OUT_W  (acc_i >>> SHIFT) clipped to OUT_W
//            sat_o    out 1      high when clipping occurred
// Revision : 1.0 - initial release
// ============================================================================
module sat_shift #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  acc_i,
    output logic signed [OUT_W-1:0] result_o,
    output logic                    sat_o
);

    // Limits of OUT_W expressed at IN_W; MIN is the bitwise inverse of MAX
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    logic signed [IN_W-1:0] shifted_w;

    assign shifted_w = acc_i >>> SHIFT;

    always_comb begin
        sat_o    = 1'b0;
        result_o = shifted_w[OUT_W-1:0];
        if (shifted_w > MAX_V) begin
            sat_o    = 1'b1;
            result_o = MAX_V[OUT_W-1:0];
        end else if (shifted_w < MIN_V) begin
            sat_o    = 1'b1;
            result_o = MIN_V[OUT_W-1:0];
        end
    end

endmodule : sat_shift
`default_nettype wire

// File: rtl/weight_rom_mac.sv
`default_nettype none
// ============================================================================
// Module   : weight_rom_mac
// Purpose  : Walks a 256x16 weight pROM (bypass mode, 1-cycle latency) over
//            addresses 0..N_TAPS-1, multiplies each signed weight with one
//            unsigned activation from a valid/ready stream, accumulates the
//            dot product and presents it shifted and saturated.
// Ports    : clk, reset         clock, synchronous active-high reset
//            start              begin a dot product (IDLE only)
//            x_data/x_valid/x_ready   activation stream
//            rom_ad/rom_ce/rom_oce/rom_reset/rom_dout   pROM pins
//            busy               high outside IDLE
//            result/sat         saturated result and clip flag, held
//            result_valid       one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module weight_rom_mac
    import nn_pkg::*;
#(
    parameter int N_TAPS = 150,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       x_data,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [7:0]       rom_ad,
    output logic             rom_ce,
    output logic             rom_oce,
    output logic             rom_reset,
    input  logic [15:0]      rom_dout,
    output logic             busy,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    output logic             sat
);

    localparam logic [7:0] LAST_TAP = 8'(N_TAPS - 1);

    mac_state_e               state_q;
    logic [7:0]               addr_q;
    logic [7:0]               tap_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] prod_d;
    logic                     prod_vld_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [OUT_W-1:0]         result_q;
    logic                     sat_q;
    logic                     result_valid_q;
    logic                     fire;
    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] act_ext;
    logic signed [OUT_W-1:0]  clip_res;
    logic                     clip_sat;

    assign x_ready   = (state_q == ST_RUN);
    assign fire      = x_valid & x_ready;
    // The ROM only advances on a fire, so its output holds the pending weight
    // across stalls; PRIME issues the read of address 0 ahead of the first fire.
    assign rom_ce    = (state_q == ST_PRIME) | fire;
    assign rom_ad    = addr_q;
    assign rom_oce   = 1'b1;
    assign rom_reset = reset;
    assign busy      = (state_q != ST_IDLE);

    assign result       = result_q;
    assign sat          = sat_q;
    assign result_valid = result_valid_q;

    assign weight_ext = {{(PROD_W-16){rom_dout[15]}}, rom_dout};
    assign act_ext    = {{(PROD_W-8){1'b0}}, x_data};
    assign prod_d     = weight_ext * act_ext;
    assign acc_d      = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    sat_shift #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .acc_i    (acc_q),
        .result_o (clip_res),
        .sat_o    (clip_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= 8'd0;
            tap_q          <= 8'd0;
            prod_q         <= '0;
            prod_vld_q     <= 1'b0;
            acc_q          <= '0;
            result_q       <= '0;
            sat_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            // Two-stage pipe: multiply on fire, accumulate one cycle later
            prod_vld_q     <= fire;
            if (fire) begin
                prod_q <= prod_d;
            end
            if (prod_vld_q) begin
                acc_q <= acc_d;
            end

            case (state_q)
                ST_IDLE: begin
                    acc_q      <= '0;
                    tap_q      <= 8'd0;
                    prod_vld_q <= 1'b0;
                    addr_q     <= 8'd0;
                    if (start) begin
                        state_q <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    addr_q  <= 8'd1;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (fire) begin
                        addr_q <= addr_q + 8'd1;
                        tap_q  <= tap_q + 8'd1;
                        if (tap_q == LAST_TAP) begin
                            state_q <= ST_DRAIN1;
                        end
                    end
                end
                ST_DRAIN1: begin
                    state_q <= ST_DRAIN2;
                end
                ST_DRAIN2: begin
                    result_q       <= clip_res;
                    sat_q          <= clip_sat;
                    result_valid_q <= 1'b1;
                    state_q        <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : weight_rom_mac
`default_nettype wire

// File: tb/tb_weight_rom_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_rom_mac
// Purpose  : Self-checking bench for weight_rom_mac with N_TAPS=4, SHIFT=0,
//            driving a behavioural bypass-mode pROM and a scoreboard of
//            expected dot-product results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_rom_mac;

    localparam int N     = 4;
    localparam int OUT_W = 16;

    typedef struct {
        logic signed [63:0] res;
        logic [63:0]        sat;
        int                 lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  x_data;
    logic        x_valid;
    logic        x_ready;
    logic [7:0]  rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [15:0] rom_dout;
    logic        busy;
    logic [OUT_W-1:0] result;
    logic        result_valid;
    logic        sat;

    logic [15:0] rom_mem [0:255];
    int          xs [0:N-1];
    exp_t        sb [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    weight_rom_mac #(
        .N_TAPS (N),
        .ACC_W  (32),
        .SHIFT  (0),
        .OUT_W  (OUT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .x_data       (x_data),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .rom_ad       (rom_ad),
        .rom_ce       (rom_ce),
        .rom_oce      (rom_oce),
        .rom_reset    (rom_reset),
        .rom_dout     (rom_dout),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .sat          (sat)
    );

    // Bypass-mode pROM: one-cycle read latency, output held while ce is low
    always @(posedge clk) begin
        if (rom_reset)   rom_dout <= 16'h0000;
        else if (rom_ce) rom_dout <= rom_mem[rom_ad];
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input logic [15:0] w, input int x);
        for (int i = 0; i < 256; i++) rom_mem[i] = w;
        for (int i = 0; i < N; i++) xs[i] = x;
    endtask

    task automatic fill_list(input logic [15:0] w0, w1, w2, w3,
                             input int x0, x1, x2, x3);
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'h5A5A;
        rom_mem[0] = w0; rom_mem[1] = w1; rom_mem[2] = w2; rom_mem[3] = w3;
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    endtask

    // One complete dot product; stall=1 toggles x_valid 1/0 during RUN,
    // noise=1 holds start high through RUN (must be ignored).
    task automatic run(input string tag, input bit stall, input bit noise);
        longint acc = 0;
        longint r;
        exp_t   e;
        exp_t   got;
        int     idx = 0;
        int     rc = 0;
        int     ce_bad = 0;
        bit     done = 1'b0;
        logic [63:0] ad_seen [$];

        for (int i = 0; i < N; i++)
            acc += longint'($signed(rom_mem[i])) * longint'(xs[i]);
        r     = acc;
        e.res = (r > 32767) ? 64'sd32767 : (r < -32768) ? -64'sd32768 : r;
        e.sat = ((r > 32767) || (r < -32768)) ? 64'd1 : 64'd0;
        e.lat = 8 + (stall ? (N - 1) : 0);
        sb.push_back(e);

        @(negedge clk);
        start   = 1'b1;
        x_valid = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            start = noise && x_ready;
            if (k == 1) begin
                check({tag, "_prime_busy"}, busy, 1);
                check({tag, "_prime_ready"}, x_ready, 0);
            end
            if (result_valid) begin
                check({tag, "_sb_nonempty"}, sb.size(), 1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check({tag, "_result"}, $signed(result), got.res);
                    check({tag, "_sat"}, sat, got.sat);
                    check({tag, "_latency"}, k, got.lat);
                end
                done = 1'b1;
            end
            if (x_ready) begin
                x_valid = !stall || (rc % 2 == 0);
                rc++;
                x_data  = (idx < N) ? 8'(xs[idx]) : 8'd0;
                #1;
                if (rom_ce !== x_valid) ce_bad++;
                if (rom_ce) ad_seen.push_back(64'(rom_ad));
                if (x_valid) idx++;
            end else begin
                x_valid = 1'b0;
                #1;
                if (rom_ce) ad_seen.push_back(64'(rom_ad));
            end
        end
        start = 1'b0;
        if (!done) check({tag, "_timeout"}, 0, 1);
        check({tag, "_ce_vs_fire"}, ce_bad, 0);
        check({tag, "_ad_count"}, ad_seen.size(), N + 1);
        for (int i = 0; i < ad_seen.size() && i <= N; i++)
            check($sformatf("%s_ad%0d", tag, i), ad_seen[i], i);

        // Pulse is one cycle wide; result is held afterwards
        @(negedge clk);
        check({tag, "_rv_pulse"}, result_valid, 0);
        check({tag, "_idle"}, busy, 0);
        repeat (3) @(negedge clk);
        check({tag, "_result_held"}, $signed(result), e.res);
    endtask

    initial begin
        int rv_count;
        reset   = 1'b1;
        start   = 1'b0;
        x_valid = 1'b0;
        x_data  = 8'd0;
        fill_const(16'h0000, 0);
        repeat (3) @(negedge clk);
        check("rst_x_ready", x_ready, 0);
        check("rst_rom_ce", rom_ce, 0);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_sat", sat, 0);
        check("rst_result", result, 0);
        check("rst_rom_ad", rom_ad, 0);
        check("rst_rom_oce", rom_oce, 1);
        check("rst_rom_reset", rom_reset, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rom_reset_follows", rom_reset, 0);

        fill_const(16'h0001, 1);   run("ones", 1'b0, 1'b0);
        fill_const(16'hFFFF, 2);   run("neg", 1'b0, 1'b0);
        fill_const(16'h7FFF, 255); run("satpos", 1'b0, 1'b0);
        fill_const(16'h8000, 255); run("satneg", 1'b0, 1'b0);
        fill_list(16'd1, 16'd2, 16'd3, 16'd4, 10, 20, 30, 40);
        run("stall", 1'b1, 1'b0);

        // Abort in the third RUN cycle
        fill_const(16'h0100, 7);
        @(negedge clk);
        start   = 1'b1;
        x_valid = 1'b1;
        x_data  = 8'd7;
        @(negedge clk);            // cycle 1: PRIME
        start = 1'b0;
        repeat (3) @(negedge clk); // cycles 2..4: RUN
        check("abort_in_run", x_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_x_ready", x_ready, 0);
        check("abort_rom_ce", rom_ce, 0);
        check("abort_rom_ad", rom_ad, 0);
        check("abort_result", result, 0);
        check("abort_sat", sat, 0);
        check("abort_result_valid", result_valid, 0);
        reset   = 1'b0;
        x_valid = 1'b0;
        rv_count = 0;
        repeat (15) begin
            @(negedge clk);
            if (result_valid) rv_count++;
        end
        check("abort_no_rv", rv_count, 0);

        fill_list(16'd1, 16'd2, 16'd3, 16'd4, 10, 20, 30, 40);
        run("noise", 1'b0, 1'b1);
        fill_list(16'hFFFD, 16'd5, 16'hFFF9, 16'd100, 200, 3, 9, 1);
        run("fresh", 1'b0, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_weight_rom_mac
`default_nettype wire
